// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU. It resolves rs/rt forwarding from EX/MEM and MEM/WB
// and raises the load-use hazard request toward IF/ID.
module alu_issue_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter logic [5:0]  NOP_FUN = 6'b000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic [5:0]        id_alufun,
    input  logic              id_sign,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_dst,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_dst,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_fun,
    output logic              alu_sign,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              load_use_stall
);

    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FUN_W   = 6;

    logic [DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [DATA_W-1:0]  rt_data_q, rt_data_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [REG_AW-1:0]  rs_q, rs_d;
    logic [REG_AW-1:0]  rt_q, rt_d;
    logic [REG_AW-1:0]  dst_q, dst_d;
    logic [FUN_W-1:0]   alufun_q, alufun_d;
    logic               sign_q, sign_d;
    logic               alusrc1_q, alusrc1_d;
    logic               alusrc2_q, alusrc2_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q, memread_d;
    logic               memwrite_q, memwrite_d;

    logic [DATA_W-1:0]  fwd_rs;
    logic [DATA_W-1:0]  fwd_rt;

    // Next-state: flush beats stall, stall beats load. A bubble matches the reset image.
    always_comb begin
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        dst_d      = dst_q;
        alufun_d   = alufun_q;
        sign_d     = sign_q;
        alusrc1_d  = alusrc1_q;
        alusrc2_d  = alusrc2_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        if (flush) begin
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
            shamt_d    = '0;
            rs_d       = '0;
            rt_d       = '0;
            dst_d      = '0;
            alufun_d   = NOP_FUN;
            sign_d     = 1'b1;
            alusrc1_d  = 1'b0;
            alusrc2_d  = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (!stall) begin
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            rs_d       = id_rs;
            rt_d       = id_rt;
            dst_d      = id_dst;
            alufun_d   = id_alufun;
            sign_d     = id_sign;
            alusrc1_d  = id_alusrc1;
            alusrc2_d  = id_alusrc2;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            dst_q      <= '0;
            alufun_q   <= NOP_FUN;
            sign_q     <= 1'b1;
            alusrc1_q  <= 1'b0;
            alusrc2_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
        end else begin
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            dst_q      <= dst_d;
            alufun_q   <= alufun_d;
            sign_q     <= sign_d;
            alusrc1_q  <= alusrc1_d;
            alusrc2_q  <= alusrc2_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
        end
    end

    // Forwarding: EX/MEM is the younger result and wins. r0 is hardwired, so it is never forwarded.
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        if (exmem_regwrite && (exmem_dst != '0) && (exmem_dst == rs_q)) begin
            fwd_rs = exmem_data;
        end else if (memwb_regwrite && (memwb_dst != '0) && (memwb_dst == rs_q)) begin
            fwd_rs = memwb_data;
        end
        if (exmem_regwrite && (exmem_dst != '0) && (exmem_dst == rt_q)) begin
            fwd_rt = exmem_data;
        end else if (memwb_regwrite && (memwb_dst != '0) && (memwb_dst == rt_q)) begin
            fwd_rt = memwb_data;
        end
    end

    assign alu_a          = alusrc1_q ? DATA_W'(shamt_q) : fwd_rs;
    assign alu_b          = alusrc2_q ? imm_q : fwd_rt;
    assign alu_fun        = alufun_q;
    assign alu_sign       = sign_q;
    assign ex_store_data  = fwd_rt;
    assign ex_dst         = dst_q;
    assign ex_regwrite    = regwrite_q;
    assign ex_memread     = memread_q;
    assign ex_memwrite    = memwrite_q;

    assign load_use_stall = memread_q && (dst_q != '0) && ((dst_q == id_rs) || (dst_q == id_rt));

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. It checks the reset image, loading, forwarding priority,
// operand selection, the load-use request, flush/stall priority and asynchronous reset.
module tb_alu_issue_stage;

    logic        clk, reset, stall, flush;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
    logic [5:0]  id_alufun;
    logic        id_sign, id_alusrc1, id_alusrc2, id_regwrite, id_memread, id_memwrite;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_dst, memwb_dst;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_fun;
    logic        alu_sign, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;
    logic [4:0]  ex_dst;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_alusrc1(id_alusrc1),
        .id_alusrc2(id_alusrc2), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_dst(exmem_dst), .exmem_data(exmem_data),
        .memwb_regwrite(memwb_regwrite), .memwb_dst(memwb_dst), .memwb_data(memwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_store_data(ex_store_data), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
        id_rs = '0; id_rt = '0; id_dst = '0; id_alufun = '0; id_sign = 1'b0;
        id_alusrc1 = 1'b0; id_alusrc2 = 1'b0;
        id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 1'b0; exmem_dst = '0; exmem_data = '0;
        memwb_regwrite = 1'b0; memwb_dst = '0; memwb_data = '0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; stall = 1'b1; flush = 1'b0;
        clear_id();
        clear_fwd();
        id_sign = 1'b0;

        // Reset image; stall is held so that releasing reset loads nothing.
        tick(); tick();
        chk("rst_fun",  32'(alu_fun),  32'h0);
        chk("rst_sign", 32'(alu_sign), 32'h1);
        reset = 1'b1;
        tick();
        chk("post_rst_fun",  32'(alu_fun),     32'h0);
        chk("post_rst_sign", 32'(alu_sign),    32'h1);
        chk("post_rst_a",    alu_a,            32'h0);
        chk("post_rst_b",    alu_b,            32'h0);
        chk("post_rst_rw",   32'(ex_regwrite), 32'h0);
        chk("post_rst_mr",   32'(ex_memread),  32'h0);

        // Plain load, no forwarding.
        stall = 1'b0;
        id_rs = 5'd5; id_rs_data = 32'h8000_0001;
        id_rt = 5'd6; id_rt_data = 32'h8000_0001;
        id_alufun = 6'b000000; id_sign = 1'b0; id_dst = 5'd3; id_regwrite = 1'b1;
        tick();
        chk("ld_a",    alu_a,             32'h8000_0001);
        chk("ld_b",    alu_b,             32'h8000_0001);
        chk("ld_sign", 32'(alu_sign),     32'h0);
        chk("ld_dst",  32'(ex_dst),       32'h3);
        chk("ld_rw",   32'(ex_regwrite),  32'h1);

        // Forwarding priority on the held instruction.
        stall = 1'b1;
        exmem_regwrite = 1'b1; exmem_dst = 5'd5; exmem_data = 32'h8000_0005;
        memwb_regwrite = 1'b1; memwb_dst = 5'd5; memwb_data = 32'h1111_1111;
        #1;
        chk("fwd_exmem_prio", alu_a, 32'h8000_0005);
        chk("fwd_b_none",     alu_b, 32'h8000_0001);
        memwb_dst = 5'd6;
        #1;
        chk("fwd_memwb_b",  alu_b,         32'h1111_1111);
        chk("fwd_memwb_st", ex_store_data, 32'h1111_1111);
        exmem_regwrite = 1'b0;
        memwb_dst = 5'd0;
        #1;
        chk("fwd_exmem_we0", alu_a, 32'h8000_0001);
        exmem_regwrite = 1'b1; exmem_dst = 5'd0; exmem_data = 32'hDEAD_0000;
        #1;
        chk("fwd_r0_a", alu_a, 32'h8000_0001);
        chk("fwd_r0_b", alu_b, 32'h8000_0001);

        // Shift: A takes shamt, B takes rt.
        clear_fwd();
        stall = 1'b0;
        id_alusrc1 = 1'b1; id_shamt = 5'd4; id_alusrc2 = 1'b0;
        id_rt_data = 32'hFFFF_FFFF; id_alufun = 6'b100000;
        tick();
        chk("sh_a",   alu_a,         32'h0000_0004);
        chk("sh_b",   alu_b,         32'hFFFF_FFFF);
        chk("sh_fun", 32'(alu_fun),  32'h20);

        // Immediate B; store data still carries the forwarded rt.
        id_alusrc1 = 1'b0; id_alusrc2 = 1'b1; id_imm = 32'h0000_ABCD;
        id_rt = 5'd7; id_rt_data = 32'h1234_5678;
        tick();
        exmem_regwrite = 1'b1; exmem_dst = 5'd7; exmem_data = 32'h7777_7777;
        #1;
        chk("imm_b",    alu_b,         32'h0000_ABCD);
        chk("imm_st",   ex_store_data, 32'h7777_7777);
        chk("imm_a_rs", alu_a,         32'h8000_0001);
        clear_fwd();

        // Load-use: lw r8, the following instruction reads r8 as rt.
        clear_id();
        id_memread = 1'b1; id_regwrite = 1'b1; id_dst = 5'd8; id_rs = 5'd2;
        tick();
        clear_id();
        id_rs = 5'd9; id_rt = 5'd9;
        #1;
        chk("lu_nomatch", 32'(load_use_stall), 32'h0);
        id_rt = 5'd8;
        #1;
        chk("lu_rt",      32'(load_use_stall), 32'h1);
        chk("lu_exmr",    32'(ex_memread),     32'h1);
        id_rt = 5'd1; id_rs = 5'd8;
        #1;
        chk("lu_rs",      32'(load_use_stall), 32'h1);
        flush = 1'b1; stall = 1'b1;
        id_alufun = 6'b111111; id_dst = 5'd9; id_memread = 1'b1;
        tick();
        chk("fl_mr",  32'(ex_memread),     32'h0);
        chk("fl_dst", 32'(ex_dst),         32'h0);
        chk("fl_fun", 32'(alu_fun),        32'h0);
        chk("fl_rw",  32'(ex_regwrite),    32'h0);
        chk("fl_lu",  32'(load_use_stall), 32'h0);
        chk("fl_a",   alu_a,               32'h0);
        flush = 1'b0;

        // A load with destination r0 never raises the hazard.
        stall = 1'b0;
        clear_id();
        id_memread = 1'b1; id_dst = 5'd0;
        tick();
        clear_id();
        #1;
        chk("lu_r0", 32'(load_use_stall), 32'h0);

        // Hold for three cycles while the ID inputs keep changing.
        clear_id();
        id_alufun = 6'b010101; id_dst = 5'd12; id_rs = 5'd3; id_rs_data = 32'hCAFE_BABE;
        id_memwrite = 1'b1;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_alufun = 6'(i + 1); id_dst = 5'(i + 20); id_rs_data = 32'(i);
            id_memwrite = 1'b0; id_alusrc1 = 1'b1; id_shamt = 5'd31;
            tick();
            chk("st_fun", 32'(alu_fun),     32'h15);
            chk("st_dst", 32'(ex_dst),      32'hC);
            chk("st_a",   alu_a,            32'hCAFE_BABE);
            chk("st_mw",  32'(ex_memwrite), 32'h1);
        end

        // Asynchronous reset in the middle of a stall.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_fun",  32'(alu_fun),     32'h0);
        chk("arst_sign", 32'(alu_sign),    32'h1);
        chk("arst_dst",  32'(ex_dst),      32'h0);
        chk("arst_mw",   32'(ex_memwrite), 32'h0);
        reset = 1'b1;
        tick();
        chk("arst_hold_a",   alu_a,         32'h0);
        chk("arst_hold_fun", 32'(alu_fun),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded instruction fields at the end of ID and resolves operand forwarding from EX/MEM and MEM/WB.
- Drives the ALU inputs A, B, ALUFun and Sign, plus the store data and control bits passed down to EX/MEM.
- Also raises the load-use hazard request that the front end uses to stall.

Parameters:
- DATA_W, 32, datapath width; must match the ALU A/B/Z width.
- REG_AW, 5, register-address width.
- NOP_FUN, 6'b000000, ALUFun loaded on reset and flush (ADD).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  global pipeline freeze; all registers hold.
- flush  in  1  load a bubble on the next edge.
- id_rs_data  in  DATA_W  register-file read of rs.
- id_rt_data  in  DATA_W  register-file read of rt.
- id_imm  in  DATA_W  extended immediate.
- id_shamt  in  5  shift amount.
- id_rs  in  REG_AW  rs address.
- id_rt  in  REG_AW  rt address.
- id_dst  in  REG_AW  destination register address.
- id_alufun  in  6  ALU function code.
- id_sign  in  1  signed compare/overflow select.
- id_alusrc1  in  1  1 = A takes {27'b0, shamt}; 0 = A takes rs.
- id_alusrc2  in  1  1 = B takes imm; 0 = B takes rt.
- id_regwrite  in  1  control bit passed down.
- id_memread  in  1  control bit passed down.
- id_memwrite  in  1  control bit passed down.
- exmem_regwrite  in  1  EX/MEM forwarding source: write enable.
- exmem_dst  in  REG_AW  EX/MEM forwarding source: destination.
- exmem_data  in  DATA_W  EX/MEM forwarding source: data.
- memwb_regwrite  in  1  MEM/WB forwarding source: write enable.
- memwb_dst  in  REG_AW  MEM/WB forwarding source: destination.
- memwb_data  in  DATA_W  MEM/WB forwarding source: data.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_fun  out  6  to ALU ALUFun.
- alu_sign  out  1  to ALU Sign.
- ex_store_data  out  DATA_W  forwarded rt, used for stores.
- ex_dst  out  REG_AW  registered destination.
- ex_regwrite  out  1  registered control.
- ex_memread  out  1  registered control.
- ex_memwrite  out  1  registered control.
- load_use_stall  out  1  hazard request to IF/ID.

Behaviour:
- Registered fields: rs_data, rt_data, imm, shamt, rs, rt, dst, alufun, sign, alusrc1, alusrc2, regwrite, memread, memwrite.
- Reset (reset=0, asynchronous): every register clears to 0, except alufun=NOP_FUN and sign=1. Outputs then read alu_a=0, alu_b=0, alu_fun=NOP_FUN, alu_sign=1, and all ex_* controls are 0.
- Edge priority: flush > stall > load.
  - flush=1: bubble loaded. Control bits = 0, dst = 0, alufun = NOP_FUN, data fields = 0. This applies even when stall=1 in the same cycle.
  - stall=1 with flush=0: all registers hold.
  - Otherwise: load all id_* fields.
- Latency: ID fields appear on the ALU inputs one cycle after capture. Forwarding muxes are combinational from the registered fields and the live forwarding inputs, so results update the same cycle the forwarding inputs change.
- Forwarded rs value (fwd_rs):
  - exmem_data if exmem_regwrite && exmem_dst!=0 && exmem_dst==rs.
  - else memwb_data if memwb_regwrite && memwb_dst!=0 && memwb_dst==rs.
  - else registered rs_data.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Forwarded rt value (fwd_rt): same rule using rt.
- Operand selection:
  - alu_a = alusrc1 ? {27'b0, shamt} : fwd_rs.
  - alu_b = alusrc2 ? imm : fwd_rt.
  - ex_store_data = fwd_rt, regardless of alusrc2.
- load_use_stall (combinational) = memread && dst!=0 && (dst==id_rs || dst==id_rt). The external controller answers it by holding IF/ID and asserting flush to this stage for one cycle; this block does not self-insert.
- Reset mid-stall or mid-flush: reset dominates immediately. After release, the stage holds a bubble.
- Shamt is zero-extended. Only alu_a[4:0] is meaningful to the shifter.

Test Plan:
- Reset=0 then release, no load → alu_fun=6'b000000, alu_sign=1, alu_a=alu_b=0, ex_regwrite=0.
- Load rs=5, rs_data=32'h80000001, rt=6, rt_data=32'h80000001, alufun=0, sign=0, no forwarding → next cycle alu_a=alu_b=32'h80000001, alu_sign=0.
- Same instruction with exmem(regwrite=1, dst=5, data=32'h80000005) and memwb(regwrite=1, dst=5, data=32'h11111111) → alu_a=32'h80000005 (EX/MEM priority). Then exmem_dst=0 with data=32'hDEAD0000 and memwb_dst=0 → alu_a reverts to 32'h80000001 (rs_data; no forwarding from register 0).
- Shift op: alusrc1=1, shamt=4, alusrc2=0, rt_data=32'hFFFFFFFF, alufun=6'b100000 → alu_a=32'h00000004, alu_b=32'hFFFFFFFF.
- Registered lw (memread=1, dst=8), next ID has id_rt=8 → load_use_stall=1. Then flush=1 with stall=1 → next cycle ex_memread=0, ex_dst=0, alu_fun=NOP_FUN, and load_use_stall drops.
- Stall=1 for 3 cycles with changing id_* inputs → alu_fun, ex_dst and the registered fields all unchanged.
